// File: rtl/spi_word_queue.sv
`default_nettype none
// spi_word_queue: TX/RX word FIFOs around a launch controller for an SPI master.
// Define SPI_WORD_QUEUE_LEVEL_EN to add the tx_level_o / rx_level_o occupancy outputs.
module spi_word_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [WIDTH-1:0]       wr_data_bi,
  input  logic                   wr_i,
  output logic                   tx_full_o,
  output logic [WIDTH-1:0]       rd_data_bo,
  input  logic                   rd_i,
  output logic                   rx_empty_o,
  output logic [WIDTH-1:0]       data_tx_bo,
  output logic                   data_tx_wr_o,
  input  logic                   busy_i,
  input  logic [WIDTH-1:0]       data_rx_bi,
  input  logic                   data_rx_wr_i,
`ifdef SPI_WORD_QUEUE_LEVEL_EN
  output logic [$clog2(DEPTH):0] tx_level_o,
  output logic [$clog2(DEPTH):0] rx_level_o,
`endif
  output logic                   idle_o
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [WIDTH-1:0] rx_mem [DEPTH];
  ptr_t tx_wptr, tx_rptr, rx_wptr, rx_rptr;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;

  // Extra pointer MSB distinguishes a full queue from an empty one.
  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);

  assign tx_push = wr_i && !tx_full;
  assign rx_pop  = rd_i && !rx_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A launch is only allowed when the returning word is guaranteed an RX slot.
  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty && !rx_full) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        tx_pop    = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (data_rx_wr_i) begin
          rx_push   = !rx_full;
          state_nxt = IDLE;
        end else if (busy_i) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (data_rx_wr_i) begin
          rx_push   = !rx_full;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + ptr_t'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + ptr_t'(1);
      if (rx_push) rx_wptr <= rx_wptr + ptr_t'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= wr_data_bi;
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= data_rx_bi;
  end

  assign tx_full_o    = tx_full;
  assign rx_empty_o   = rx_empty;
  assign data_tx_wr_o = (state == LAUNCH);
  assign data_tx_bo   = data_tx_wr_o ? tx_mem[tx_rptr[AW-1:0]] : '0;
  // Memory is not cleared by reset, so the head is masked while the queue is empty.
  assign rd_data_bo   = rx_empty ? '0 : rx_mem[rx_rptr[AW-1:0]];
  assign idle_o       = (state == IDLE) && tx_empty;

`ifdef SPI_WORD_QUEUE_LEVEL_EN
  assign tx_level_o = tx_wptr - tx_rptr;
  assign rx_level_o = rx_wptr - rx_rptr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_word_queue.sv
`default_nettype none
// tb_spi_word_queue: queue-based reference model plus directed and random stimulus.
module tb_spi_word_queue;

  localparam int DEPTH = 8;
  localparam int W     = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [W-1:0]  wr_data_bi = '0;
  logic          wr_i = 1'b0;
  logic          tx_full_o;
  logic [W-1:0]  rd_data_bo;
  logic          rd_i = 1'b0;
  logic          rx_empty_o;
  logic [W-1:0]  data_tx_bo;
  logic          data_tx_wr_o;
  logic          busy_i = 1'b0;
  logic [W-1:0]  data_rx_bi = '0;
  logic          data_rx_wr_i = 1'b0;
  logic          idle_o;
`ifdef SPI_WORD_QUEUE_LEVEL_EN
  logic [3:0]    tx_level_o;
  logic [3:0]    rx_level_o;
`endif

  spi_word_queue #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_data_bi   (wr_data_bi),
    .wr_i         (wr_i),
    .tx_full_o    (tx_full_o),
    .rd_data_bo   (rd_data_bo),
    .rd_i         (rd_i),
    .rx_empty_o   (rx_empty_o),
    .data_tx_bo   (data_tx_bo),
    .data_tx_wr_o (data_tx_wr_o),
    .busy_i       (busy_i),
    .data_rx_bi   (data_rx_bi),
    .data_rx_wr_i (data_rx_wr_i),
`ifdef SPI_WORD_QUEUE_LEVEL_EN
    .tx_level_o   (tx_level_o),
    .rx_level_o   (rx_level_o),
`endif
    .idle_o       (idle_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: two word queues and a transfer phase (0 idle, 1 launching, 2 in flight).
  logic [W-1:0] mtx[$];
  logic [W-1:0] mrx[$];
  int           mphase = 0;
  int           mnext;
  bit           m_txpush, m_rxpush, m_rxpop, m_launch;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtx.delete();
      mrx.delete();
      mphase = 0;
    end else begin
      m_launch = (mphase == 1);
      m_txpush = wr_i && (mtx.size() < DEPTH);
      m_rxpop  = rd_i && (mrx.size() > 0);
      m_rxpush = (mphase == 2) && data_rx_wr_i && (mrx.size() < DEPTH);
      mnext    = mphase;
      if (mphase == 0 && mtx.size() > 0 && mrx.size() + 1 <= DEPTH) mnext = 1;
      else if (mphase == 1) mnext = 2;
      else if (mphase == 2 && data_rx_wr_i) mnext = 0;
      if (m_launch) void'(mtx.pop_front());
      if (m_txpush) mtx.push_back(wr_data_bi);
      if (m_rxpop)  void'(mrx.pop_front());
      if (m_rxpush) mrx.push_back(data_rx_bi);
      mphase = mnext;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [W-1:0] e_txd, e_rd;
    e_txd = (mphase == 1 && mtx.size() > 0) ? mtx[0] : '0;
    e_rd  = (mrx.size() > 0) ? mrx[0] : '0;
    chk("m_tx_wr",    64'(data_tx_wr_o), 64'(mphase == 1));
    chk("m_tx_data",  64'(data_tx_bo),   64'(e_txd));
    chk("m_tx_full",  64'(tx_full_o),    64'(mtx.size() == DEPTH));
    chk("m_rx_empty", 64'(rx_empty_o),   64'(mrx.size() == 0));
    chk("m_rd_data",  64'(rd_data_bo),   64'(e_rd));
    chk("m_idle",     64'(idle_o),       64'(mphase == 0 && mtx.size() == 0));
`ifdef SPI_WORD_QUEUE_LEVEL_EN
    chk("m_tx_level", 64'(tx_level_o),   64'(mtx.size()));
    chk("m_rx_level", 64'(rx_level_o),   64'(mrx.size()));
`endif
  endtask

  // Master behaviour when auto_m is set; otherwise master inputs come from the caller.
  bit auto_m = 0;
  bit m_act  = 0;
  int m_tmr  = 0;

  // Drives one cycle of inputs just after the rising edge, then checks at the falling edge.
  task automatic step(input logic wr, input logic [W-1:0] wd, input logic rd,
                      input logic bsy, input logic rxw, input logic [W-1:0] rxd);
    @(posedge clk_i);
    #1;
    wr_i = wr; wr_data_bi = wd; rd_i = rd;
    if (auto_m) begin
      busy_i = 1'b0; data_rx_wr_i = 1'b0; data_rx_bi = $urandom;
      if (data_tx_wr_o) begin
        m_act = 1; m_tmr = $urandom_range(1, 5);
      end else if (m_act) begin
        if (m_tmr == 0) begin
          data_rx_wr_i = 1'b1; m_act = 0;
        end else begin
          m_tmr--; busy_i = ($urandom_range(0, 3) != 0);
        end
      end else begin
        data_rx_wr_i = ($urandom_range(0, 19) == 0);
      end
    end else begin
      busy_i = bsy; data_rx_wr_i = rxw; data_rx_bi = rxd;
    end
    @(negedge clk_i);
    compare_model();
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    auto_m = 0; m_act = 0;
    rst_ni = 1'b0;
    idle_step();
    rst_ni = 1'b1;
  endtask

  task automatic do_xfer(input logic [W-1:0] wd, input logic [W-1:0] rxd, input logic rd_with);
    step(1'b1, wd, 1'b0, 1'b0, 1'b0, '0);
    idle_step();
    idle_step();
    chk("xfer_launch", 64'(data_tx_wr_o), 64'd1);
    chk("xfer_word",   64'(data_tx_bo),   64'(wd));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, rd_with, 1'b0, 1'b1, rxd);
    idle_step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int launches;
    // Reset state
    idle_step();
    chk("rst_tx_full",  64'(tx_full_o),    64'd0);
    chk("rst_rx_empty", 64'(rx_empty_o),   64'd1);
    chk("rst_idle",     64'(idle_o),       64'd1);
    chk("rst_rd_data",  64'(rd_data_bo),   64'd0);
    chk("rst_tx_wr",    64'(data_tx_wr_o), 64'd0);
    rst_ni = 1'b1;

    // Single transfer: launch two cycles after the push, returned word at the RX head
    step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, '0);
    idle_step();
    chk("lat_no_pulse_yet", 64'(data_tx_wr_o), 64'd0);
    idle_step();
    chk("lat_pulse",      64'(data_tx_wr_o), 64'd1);
    chk("lat_data",       64'(data_tx_bo),   64'hA5A5_0001);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    chk("tx_data_zero",   64'(data_tx_bo),   64'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    idle_step();
    chk("rx_not_empty",   64'(rx_empty_o),   64'd0);
    chk("rx_head",        64'(rd_data_bo),   64'h1234_5678);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    idle_step();
    chk("rx_popped",      64'(rx_empty_o),   64'd1);

    // Read on an empty RX queue, then verify the next word lands at the head
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    idle_step();
    chk("empty_rd_empty", 64'(rx_empty_o),   64'd1);
    chk("empty_rd_data",  64'(rd_data_bo),   64'd0);
    do_xfer(32'h0000_0042, 32'hBEEF_0001, 1'b0);
    chk("empty_rd_head",  64'(rd_data_bo),   64'hBEEF_0001);

    // Simultaneous RX push and pop with three words queued
    do_reset();
    do_xfer(32'h10, 32'hC000_0001, 1'b0);
    do_xfer(32'h11, 32'hC000_0002, 1'b0);
    do_xfer(32'h12, 32'hC000_0003, 1'b0);
    do_xfer(32'h13, 32'hC000_0004, 1'b1);
    chk("pushpop_head",   64'(rd_data_bo),   64'hC000_0002);
`ifdef SPI_WORD_QUEUE_LEVEL_EN
    chk("pushpop_level",  64'(rx_level_o),   64'd3);
`endif
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    chk("pushpop_two_left", 64'(rd_data_bo), 64'hC000_0004);
    idle_step();
    chk("pushpop_drained", 64'(rx_empty_o),  64'd1);

    // Nine pushes with the master busy: first launches, eight fill the queue, tenth dropped
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b1, 1'b0, '0);
      if (i == 2) begin
        chk("fill_first_launch", 64'(data_tx_wr_o), 64'd1);
        chk("fill_first_word",   64'(data_tx_bo),   64'hD000_0000);
      end
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    chk("fill_full",      64'(tx_full_o),    64'd1);
    step(1'b1, 32'hDEAD_DEAD, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    chk("fill_still_full", 64'(tx_full_o),   64'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hE000_0000);
    auto_m = 1;
    launches = 0;
    for (int k = 0; k < 300; k++) begin
      step(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
      if (data_tx_wr_o) launches++;
    end
    chk("fill_launch_count", 64'(launches), 64'd8);
    auto_m = 0;

    // RX full blocks further launches until one word is read
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_xfer(32'h100 + 32'(i), 32'hF000_0000 + 32'(i), 1'b0);
    step(1'b1, 32'h0000_0999, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      idle_step();
      chk("rxfull_no_launch", 64'(data_tx_wr_o), 64'd0);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    idle_step();
    chk("rxfull_after_pop", 64'(data_tx_wr_o), 64'd0);
    idle_step();
    chk("rxfull_relaunch",  64'(data_tx_wr_o), 64'd1);
    chk("rxfull_word",      64'(data_tx_bo),   64'h0000_0999);

    // Asynchronous reset in WAIT_DONE, then a stale receive pulse
    do_reset();
    do_xfer(32'h1111_0000, 32'hAAAA_0001, 1'b0);
    step(1'b1, 32'h2222_0000, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'h3333_0000, 1'b0, 1'b0, 1'b0, '0);
    idle_step();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    idle_step();
    chk("pre_rst_rx",   64'(rx_empty_o), 64'd0);
    chk("pre_rst_idle", 64'(idle_o),     64'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rx_empty", 64'(rx_empty_o),   64'd1);
    chk("async_rd_data",  64'(rd_data_bo),   64'd0);
    chk("async_idle",     64'(idle_o),       64'd1);
    chk("async_tx_full",  64'(tx_full_o),    64'd0);
    chk("async_tx_wr",    64'(data_tx_wr_o), 64'd0);
    chk("async_tx_data",  64'(data_tx_bo),   64'd0);
    #1;
    rst_ni = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0001);
    idle_step();
    chk("stale_rx_ignored", 64'(rx_empty_o), 64'd1);

`ifdef SPI_WORD_QUEUE_LEVEL_EN
    // Five pushes with the master stalled leave four queued
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h5000_0000 + 32'(i), 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    chk("level_tx4", 64'(tx_level_o), 64'd4);
    chk("level_rx0", 64'(rx_level_o), 64'd0);
`endif

    // Random traffic against the model
    do_reset();
    auto_m = 1;
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0),
           1'b0, 1'b0, '0);
    end
    auto_m = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
